ipl_event_fifo: RTL and testbench
=================================

Name: ipl_event_fifo

Overview:
- Parametrised successor to the bridge's interrupt-level capture path. Runs in the c200m domain.
- Debounces an interrupt-priority-level bus on CPU-clock sample strobes and queues each accepted level change with a saturating inter-event timestamp.
- The host pops entries through the status register.
- Adds capabilities the previous capture path lacked: configurable width, depth and filter length; simultaneous push/pop; sticky overflow with drop counter; flush.

Parameters:
- IPL_W, 3, width of level bus
- FIFO_DEPTH, 64, entries; any value ≥2, need not be a power of two
- STABLE_CNT, 3, consecutive identical samples required to accept a level (≥1)
- TS_W, 8, timestamp width in sample ticks
- DROP_W, 8, dropped-event counter width
- CNT_W, $clog2(FIFO_DEPTH+1), occupancy width (derived)

Ports:
- c200m  in  1  system clock
- reset  in  1  asynchronous active-high reset
- sample_tick  in  1  one-cycle strobe, CPU-clock falling edge, already synchronised
- ipl_in  in  IPL_W  active-high level, already double-registered
- pop  in  1  one-cycle read strobe from host status-register read
- flush  in  1  one-cycle strobe, empties queue
- rd_data  out  IPL_W+TS_W  {level, timestamp} of last popped entry
- rd_valid  out  1  rd_data holds a real entry
- count  out  CNT_W  occupancy
- not_empty  out  1  count != 0; drives interrupt-pending pin
- overflow  out  1  sticky: ≥1 event dropped since last flush/reset
- drop_cnt  out  DROP_W  saturating count of dropped events
- cur_level  out  IPL_W  last accepted level

Behaviour:
- Reset (async, all registers): pointers = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = 0, drop_cnt = 0, cur_level = 0, filter history = 0, timestamp counter = 0. Memory contents are don't-care.
- Filter:
  - On sample_tick, shift ipl_in into a STABLE_CNT-deep history.
  - A candidate is stable when every history entry equals ipl_in in the same cycle.
  - If stable and ≠ cur_level: accept it, cur_level <= candidate the next cycle, and raise an internal push for exactly one cycle.
  - Ticks never coincide with acceptance latency issues: at most one push per tick.
- Timestamp:
  - ts_cnt increments on every sample_tick and saturates at all-ones.
  - On push, the entry stores the current ts_cnt value and ts_cnt resets to 0 (or 1 if a tick occurs in the same cycle).
- Push:
  - count < FIFO_DEPTH, or pop in the same cycle with count > 0: write {candidate, ts} at wr_ptr. wr_ptr wraps from FIFO_DEPTH-1 to 0.
  - Otherwise drop: overflow <= 1, drop_cnt saturating +1. cur_level still updates.
- Pop:
  - count > 0: rd_data <= mem[rd_ptr], rd_valid <= 1, rd_ptr wraps as wr_ptr. Data is visible the cycle after pop.
  - count == 0: rd_data <= {cur_level, TS_W'0}, rd_valid <= 0.
- Simultaneous push and pop:
  - Both execute and count is unchanged.
  - When count == 0, the pop sees the empty case; the push lands and count becomes 1 (no bypass).
- count: +1 on push only, −1 on pop only, otherwise unchanged. Never exceeds FIFO_DEPTH, never underflows.
- not_empty: registered, equal to (count != 0) of the same cycle's registered count; no extra latency beyond count.
- Flush:
  - Highest priority. Pointers, count, overflow and drop_cnt go to 0 and rd_valid to 0.
  - A push or pop in the same cycle is discarded.
  - cur_level, filter history and ts_cnt are retained, so no spurious event follows.
- Reset mid-operation: immediate return to reset values. The first accepted level after reset is any stable non-zero value.

Decomposition:
- Shared package ipl_pkg: IPL_W default, entry field offsets (TS lsb, level msb), status-word packing constants used by the register decoder.
- One natural sub-module: ipl_stable_filter (history shift, compare, candidate/accept). The FIFO storage and pointers stay in the top.

Test Plan:
- Filter rejection: ipl_in 0→5 held 2 ticks then back to 0 (STABLE_CNT=3) → no push, count=0, cur_level=0.
- Basic capture: 0→3 held 4 ticks, 10 ticks later →6 held; pop ×2 → rd_data {3,ts}, then {6,ts≈10}, rd_valid=1; third pop → rd_valid=0, rd_data={6,0}, not_empty=0.
- Full/overflow (FIFO_DEPTH=5): 7 accepted changes, no pops → count=5, overflow=1, drop_cnt=2; 5 pops return the first 5 levels in order.
- Simultaneous push+pop at count=5 → push accepted, count stays 5, no overflow. At count=0 → count=1, rd_valid=0.
- Wrap and saturation: FIFO_DEPTH=5, 12 push/pop cycles → order preserved across wrap. 300 ticks between events (TS_W=8) → ts=255.
- Flush and reset: flush with count=3 and overflow=1 → count=0, overflow=0, cur_level kept, no new push. Assert reset mid-stream → all outputs zero on the asynchronous edge.

Source files
------------

// File: rtl/ipl_pkg.sv
// ipl_pkg -- shared definitions for the interrupt-priority-level event FIFO.
//   * IPL_W_DEF        : default width of the interrupt level bus
//   * ENTRY_TS_LSB     : bit offset of the timestamp field inside a queue entry
//   * entry_lvl_lsb/msb: bit range of the level field inside a queue entry
//   * STAT_*           : bit positions used by the register decoder when it
//                        packs the FIFO status into the host status word
//   * fifo_op_e        : which of push/pop actually execute in a cycle
package ipl_pkg;

  localparam int IPL_W_DEF = 3;

  // Queue entry layout: {level, timestamp}, timestamp in the low bits.
  localparam int ENTRY_TS_LSB = 0;

  function automatic int entry_lvl_lsb(input int ts_w);
    return ENTRY_TS_LSB + ts_w;
  endfunction

  function automatic int entry_lvl_msb(input int ipl_w, input int ts_w);
    return ENTRY_TS_LSB + ts_w + ipl_w - 1;
  endfunction

  // Host status word packing.
  localparam int STAT_NOT_EMPTY_BIT = 0;
  localparam int STAT_OVERFLOW_BIT  = 1;
  localparam int STAT_RD_VALID_BIT  = 2;
  localparam int STAT_LEVEL_LSB     = 4;
  localparam int STAT_COUNT_LSB     = 8;
  localparam int STAT_DROP_LSB      = 16;
  localparam int STAT_DATA_LSB      = 24;

  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_POP  = 2'b01,
    FIFO_OP_PUSH = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/ipl_event_fifo_filter.sv
// ipl_stable_filter -- debounces the interrupt level bus on sample ticks.
// A sample is accepted when all STABLE_CNT previously stored samples equal
// it, and it differs from the currently accepted level.
// Ports:
//   c200m       in   system clock
//   reset       in   asynchronous active-high reset
//   sample_tick in   one-cycle sample strobe
//   ipl_in      in   raw (already synchronised) level
//   cur_level   out  last accepted level
//   push        out  one-cycle pulse, the cycle cur_level first shows a new level
module ipl_stable_filter
  import ipl_pkg::*;
#(
  parameter int IPL_W      = IPL_W_DEF,
  parameter int STABLE_CNT = 3
) (
  input  logic             c200m,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic [IPL_W-1:0] ipl_in,
  output logic [IPL_W-1:0] cur_level,
  output logic             push
);

  localparam int HIST_W = STABLE_CNT * IPL_W;

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [IPL_W-1:0]  cur_level_q, cur_level_d;
  logic              push_q, push_d;
  logic              stable_s;

  // Compare every stored sample against the live input.
  always_comb begin
    stable_s = 1'b1;
    for (int i = 0; i < STABLE_CNT; i++) begin
      stable_s = stable_s & (hist_q[i*IPL_W +: IPL_W] == ipl_in);
    end
  end

  // History shift, acceptance and push pulse generation.
  always_comb begin
    hist_d      = hist_q;
    cur_level_d = cur_level_q;
    push_d      = 1'b0;
    if (sample_tick) begin
      // Newest sample enters at the bottom; the oldest falls off the top.
      hist_d = HIST_W'({hist_q, ipl_in});
      if (stable_s && (ipl_in != cur_level_q)) begin
        cur_level_d = ipl_in;
        push_d      = 1'b1;
      end else begin
        cur_level_d = cur_level_q;
        push_d      = 1'b0;
      end
    end else begin
      hist_d = hist_q;
    end
  end

  // Filter state registers.
  always_ff @(posedge c200m or posedge reset) begin
    if (reset) begin
      hist_q      <= {HIST_W{1'b0}};
      cur_level_q <= {IPL_W{1'b0}};
      push_q      <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      cur_level_q <= cur_level_d;
      push_q      <= push_d;
    end
  end

  assign cur_level = cur_level_q;
  assign push      = push_q;

endmodule

// File: rtl/ipl_event_fifo.sv
// ipl_event_fifo -- queues debounced interrupt-level changes with a
// saturating inter-event timestamp; the host pops entries one at a time.
// Ports:
//   c200m       in   system clock
//   reset       in   asynchronous active-high reset
//   sample_tick in   one-cycle CPU-clock sample strobe
//   ipl_in      in   interrupt level bus (already synchronised)
//   pop         in   one-cycle read strobe from the host
//   flush       in   one-cycle strobe, empties the queue
//   rd_data     out  {level, timestamp} of the last popped entry
//   rd_valid    out  rd_data holds a real entry
//   count       out  queue occupancy
//   not_empty   out  count != 0 (interrupt pending)
//   overflow    out  sticky: an event was dropped since last flush/reset
//   drop_cnt    out  saturating count of dropped events
//   cur_level   out  last accepted level
module ipl_event_fifo
  import ipl_pkg::*;
#(
  parameter int IPL_W      = IPL_W_DEF,
  parameter int FIFO_DEPTH = 64,
  parameter int STABLE_CNT = 3,
  parameter int TS_W       = 8,
  parameter int DROP_W     = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  c200m,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [IPL_W-1:0]      ipl_in,
  input  logic                  pop,
  input  logic                  flush,
  output logic [IPL_W+TS_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  not_empty,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic [IPL_W-1:0]      cur_level
);

  localparam int ENT_W   = IPL_W + TS_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_LSB = entry_lvl_lsb(TS_W);
  localparam int LVL_MSB = entry_lvl_msb(IPL_W, TS_W);

  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [TS_W-1:0]   TS_MAX   = {TS_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [IPL_W-1:0]  cur_level_s;
  logic              push_s;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ENT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              not_empty_q, not_empty_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;

  logic              pop_ok_s;
  logic              push_ok_s;
  logic              drop_s;
  logic              mem_we_s;
  logic [ENT_W-1:0]  entry_s;
  logic [ENT_W-1:0]  empty_word_s;
  fifo_op_e          op_s;

  ipl_stable_filter #(
    .IPL_W      (IPL_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_filter (
    .c200m       (c200m),
    .reset       (reset),
    .sample_tick (sample_tick),
    .ipl_in      (ipl_in),
    .cur_level   (cur_level_s),
    .push        (push_s)
  );

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Entry to be written and the word returned by a pop on an empty queue.
  // cur_level already holds the new level in the cycle the push pulse is high.
  always_comb begin
    entry_s                                = {ENT_W{1'b0}};
    entry_s[LVL_MSB:LVL_LSB]               = cur_level_s;
    entry_s[ENTRY_TS_LSB +: TS_W]          = ts_cnt_q;
    empty_word_s                           = {ENT_W{1'b0}};
    empty_word_s[LVL_MSB:LVL_LSB]          = cur_level_s;
  end

  // Queue control: pointers, occupancy, read port, overflow and timestamp.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    ts_cnt_d    = ts_cnt_q;
    mem_we_s    = 1'b0;

    // A pop only frees space when something is there; a full queue still
    // accepts a push if a real pop happens in the same cycle.
    pop_ok_s  = pop & ~flush & (count_q != {CNT_W{1'b0}});
    push_ok_s = push_s & ~flush & ((count_q < CNT_FULL) | pop_ok_s);
    drop_s    = push_s & ~flush & ~push_ok_s;
    op_s      = fifo_op_e'({push_ok_s, pop_ok_s});

    // Timestamp counts ticks since the last accepted event, even when the
    // event itself was dropped or flushed away.
    if (push_s) begin
      if (sample_tick) begin
        ts_cnt_d = TS_W'(1);
      end else begin
        ts_cnt_d = {TS_W{1'b0}};
      end
    end else if (sample_tick && (ts_cnt_q != TS_MAX)) begin
      ts_cnt_d = ts_cnt_q + TS_W'(1);
    end else begin
      ts_cnt_d = ts_cnt_q;
    end

    if (flush) begin
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
      rd_valid_d = 1'b0;
      overflow_d = 1'b0;
      drop_cnt_d = {DROP_W{1'b0}};
    end else begin
      if (pop_ok_s) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = ptr_next(rd_ptr_q);
      end else if (pop) begin
        rd_data_d  = empty_word_s;
        rd_valid_d = 1'b0;
      end else begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
      end

      if (push_ok_s) begin
        mem_we_s = 1'b1;
        wr_ptr_d = ptr_next(wr_ptr_q);
      end else begin
        mem_we_s = 1'b0;
      end

      if (drop_s) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != DROP_MAX) begin
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
      end else begin
        overflow_d = overflow_q;
      end

      case (op_s)
        FIFO_OP_PUSH: count_d = count_q + CNT_W'(1);
        FIFO_OP_POP:  count_d = count_q - CNT_W'(1);
        FIFO_OP_BOTH: count_d = count_q;
        FIFO_OP_IDLE: count_d = count_q;
        default:      count_d = count_q;
      endcase
    end

    not_empty_d = (count_d != {CNT_W{1'b0}});
  end

  // Control and output registers.
  always_ff @(posedge c200m or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      rd_data_q   <= {ENT_W{1'b0}};
      rd_valid_q  <= 1'b0;
      not_empty_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= {DROP_W{1'b0}};
      ts_cnt_q    <= {TS_W{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      not_empty_q <= not_empty_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      ts_cnt_q    <= ts_cnt_d;
    end
  end

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge c200m) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign not_empty = not_empty_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign cur_level = cur_level_s;

endmodule

// File: tb/tb_ipl_event_fifo.sv
// Self-checking bench for ipl_event_fifo (FIFO_DEPTH=5, DROP_W=3).
module tb_ipl_event_fifo;

  localparam int IPL_W  = 3;
  localparam int DEPTH  = 5;
  localparam int SC     = 3;
  localparam int TS_W   = 8;
  localparam int DROP_W = 3;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ENT_W  = IPL_W + TS_W;

  logic              c200m = 1'b0;
  logic              reset = 1'b1;
  logic              sample_tick = 1'b0;
  logic [IPL_W-1:0]  ipl_in = '0;
  logic              pop = 1'b0;
  logic              flush = 1'b0;
  logic [ENT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [CNT_W-1:0]  count;
  logic              not_empty;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic [IPL_W-1:0]  cur_level;

  ipl_event_fifo #(
    .IPL_W(IPL_W), .FIFO_DEPTH(DEPTH), .STABLE_CNT(SC), .TS_W(TS_W), .DROP_W(DROP_W)
  ) dut (
    .c200m(c200m), .reset(reset), .sample_tick(sample_tick), .ipl_in(ipl_in),
    .pop(pop), .flush(flush), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .not_empty(not_empty), .overflow(overflow),
    .drop_cnt(drop_cnt), .cur_level(cur_level)
  );

  always #5 c200m = ~c200m;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Level filter tracked as a run length of identical samples; queue as a
  // plain SV queue; timestamp as an unbounded tick count clamped on store.
  logic [ENT_W-1:0] m_q[$];
  logic [ENT_W-1:0] m_rd     = '0;
  bit               m_rv     = 1'b0;
  bit               m_ovf    = 1'b0;
  int               m_drops  = 0;
  int               m_ticks  = 0;
  int               m_run    = SC;
  logic [IPL_W-1:0] m_level  = '0;
  logic [IPL_W-1:0] m_last   = '0;
  bit               m_pend   = 1'b0;
  bit               model_live = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_rd = '0; m_rv = 1'b0; m_ovf = 1'b0; m_drops = 0; m_ticks = 0;
    m_run = SC; m_level = '0; m_last = '0; m_pend = 1'b0;
  endtask

  task automatic model_step();
    bit               push_now;
    int               ts;
    logic [ENT_W-1:0] ent;
    push_now = m_pend;
    ts  = (m_ticks > 255) ? 255 : m_ticks;
    ent = {m_level, TS_W'(ts)};
    if (flush) begin
      m_q.delete();
      m_ovf = 1'b0; m_drops = 0; m_rv = 1'b0;
    end else begin
      if (pop) begin
        if (m_q.size() > 0) begin
          m_rd = m_q.pop_front(); m_rv = 1'b1;
        end else begin
          m_rd = {m_level, 8'd0}; m_rv = 1'b0;
        end
      end
      if (push_now) begin
        if (m_q.size() < DEPTH) m_q.push_back(ent);
        else begin m_ovf = 1'b1; m_drops++; end
      end
    end
    if (push_now) m_ticks = sample_tick ? 1 : 0;
    else if (sample_tick) m_ticks++;
    m_pend = 1'b0;
    if (sample_tick) begin
      if (ipl_in == m_last) m_run++;
      else begin m_last = ipl_in; m_run = 1; end
      // Accepted once the current sample and SC earlier ones all agree.
      if (m_run >= SC + 1 && ipl_in != m_level) begin
        m_level = ipl_in; m_pend = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge c200m or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge c200m);
      if (!reset && model_live) begin
        chk("m_count",     32'(count),     32'(m_q.size()));
        chk("m_not_empty", 32'(not_empty), 32'(m_q.size() != 0));
        chk("m_rd_valid",  32'(rd_valid),  32'(m_rv));
        chk("m_rd_data",   32'(rd_data),   32'(m_rd));
        chk("m_overflow",  32'(overflow),  32'(m_ovf));
        chk("m_drop_cnt",  32'(drop_cnt),  32'((m_drops > 7) ? 7 : m_drops));
        chk("m_cur_level", 32'(cur_level), 32'(m_level));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit tk, input logic [IPL_W-1:0] lvl, input bit p, input bit f);
    sample_tick = tk; ipl_in = lvl; pop = p; flush = f;
    @(posedge c200m); #1;
    sample_tick = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [IPL_W-1:0] lvl);
    repeat (n) begin
      step(1'b1, lvl, 1'b0, 1'b0);
      step(1'b0, lvl, 1'b0, 1'b0);
      step(1'b0, lvl, 1'b0, 1'b0);
    end
  endtask

  task automatic do_pop();
    step(1'b0, ipl_in, 1'b1, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"},     32'(count),     32'd0);
    chk({tag, "_rd_data"},   32'(rd_data),   32'd0);
    chk({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    chk({tag, "_not_empty"}, 32'(not_empty), 32'd0);
    chk({tag, "_overflow"},  32'(overflow),  32'd0);
    chk({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
    chk({tag, "_cur_level"}, 32'(cur_level), 32'd0);
  endtask

  logic [IPL_W-1:0] lv3 [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd2};
  logic [IPL_W-1:0] lv4 [11] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    // Reset values
    @(posedge c200m); #1;
    chk_zero("rst");
    @(posedge c200m); #1;
    reset = 1'b0;
    model_live = 1'b1;

    // Filter rejection: 5 for two ticks only
    ticks(2, 3'd5);
    ticks(3, 3'd0);
    chk("rej_count", 32'(count), 32'd0);
    chk("rej_level", 32'(cur_level), 32'd0);

    // Basic capture: 3 accepted on its 4th tick (9 ticks since reset), 6 after 14
    ticks(4, 3'd3);
    chk("cap_count1", 32'(count), 32'd1);
    chk("cap_level", 32'(cur_level), 32'd3);
    ticks(10, 3'd3);
    ticks(4, 3'd6);
    chk("cap_count2", 32'(count), 32'd2);
    do_pop();
    chk("cap_pop1", 32'(rd_data), 32'({3'd3, 8'd9}));
    chk("cap_valid1", 32'(rd_valid), 32'd1);
    do_pop();
    chk("cap_pop2", 32'(rd_data), 32'({3'd6, 8'd14}));
    do_pop();
    chk("cap_pop3_valid", 32'(rd_valid), 32'd0);
    chk("cap_pop3_data", 32'(rd_data), 32'({3'd6, 8'd0}));
    chk("cap_not_empty", 32'(not_empty), 32'd0);

    // Full / overflow: 7 events into 5 slots
    for (int i = 0; i < 7; i++) ticks(4, lv3[i]);
    chk("ovf_count", 32'(count), 32'd5);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 5; i++) begin
      do_pop();
      chk("ovf_order", 32'(rd_data), 32'({lv3[i], 8'd4}));
    end
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Drop counter saturation: 5 fills then 6 more drops (2+6 -> 7)
    for (int i = 0; i < 11; i++) ticks(4, lv4[i]);
    chk("sat_drops", 32'(drop_cnt), 32'd7);
    do_pop();
    do_pop();
    chk("fl_pre_count", 32'(count), 32'd3);
    // Flush
    step(1'b0, ipl_in, 1'b0, 1'b1);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_overflow", 32'(overflow), 32'd0);
    chk("fl_drops", 32'(drop_cnt), 32'd0);
    chk("fl_valid", 32'(rd_valid), 32'd0);
    chk("fl_level", 32'(cur_level), 32'd7);
    repeat (12) step(1'b0, ipl_in, 1'b0, 1'b0);
    chk("fl_no_event", 32'(count), 32'd0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 5; i++) ticks(4, 3'(i + 1));
    ticks(3, 3'd6);
    step(1'b1, 3'd6, 1'b0, 1'b0);
    step(1'b0, 3'd6, 1'b1, 1'b0);
    chk("both_full_count", 32'(count), 32'd5);
    chk("both_full_ovf", 32'(overflow), 32'd0);
    chk("both_full_data", 32'(rd_data), 32'({3'd1, 8'd4}));
    repeat (5) do_pop();
    chk("drain_last", 32'(rd_data), 32'({3'd6, 8'd4}));
    // Simultaneous push and pop while empty: pop sees empty
    ticks(3, 3'd2);
    step(1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b0, 3'd2, 1'b1, 1'b0);
    chk("both_empty_count", 32'(count), 32'd1);
    chk("both_empty_valid", 32'(rd_valid), 32'd0);
    chk("both_empty_data", 32'(rd_data), 32'({3'd2, 8'd0}));
    chk("both_empty_ne", 32'(not_empty), 32'd1);
    do_pop();
    chk("both_empty_pop", 32'(rd_data), 32'({3'd2, 8'd4}));

    // Pointer wrap: 12 push/pop rounds
    for (int i = 0; i < 12; i++) begin
      ticks(4, 3'((i % 7) + 1));
      do_pop();
      chk("wrap_data", 32'(rd_data), 32'({3'((i % 7) + 1), 8'd4}));
    end

    // Timestamp saturation: 304 ticks between events
    ticks(300, 3'd5);
    ticks(4, 3'd7);
    do_pop();
    chk("ts_sat", 32'(rd_data), 32'({3'd7, 8'd255}));

    // Back-to-back ticks: push coincides with a tick, ts restarts at 1
    repeat (5) step(1'b1, 3'd4, 1'b0, 1'b0);
    repeat (4) step(1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b0, 3'd2, 1'b0, 1'b0);
    do_pop();
    chk("bb_first", 32'(rd_data), 32'({3'd4, 8'd4}));
    do_pop();
    chk("bb_second", 32'(rd_data), 32'({3'd2, 8'd5}));

    // Reset mid-stream
    ticks(4, 3'd3);
    chk("mid_pre_count", 32'(count), 32'd1);
    @(posedge c200m); #3;
    reset = 1'b1;
    #1;
    chk_zero("mid");
    @(posedge c200m); #1;
    reset = 1'b0;
    ticks(4, 3'd3);
    chk("post_count", 32'(count), 32'd1);
    chk("post_level", 32'(cur_level), 32'd3);
    do_pop();
    chk("post_data", 32'(rd_data), 32'({3'd3, 8'd4}));

    repeat (2) @(posedge c200m);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
